// File: rtl/imem_fetch_responder.sv
// Instruction memory behind the PC fetch port. It returns one registered word per request
// and includes a byte-stream loader that a host uses to program the memory.
module imem_fetch_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           pc_addr,
  output logic [31:0]           instruction,
  output logic                  instr_valid,
  output logic                  fetch_fault,
  input  logic                  load_mode,
  input  logic                  load_byte_vld,
  input  logic [7:0]            load_byte,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_words,
  output logic                  load_overflow
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StWrite} state_e;

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     word_q, word_d;
  logic [CntW-1:0] ptr_q, ptr_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic            mem_we;

  logic [31:0] mem [Depth];

  // A WRITE in flight already owns the slot at ptr_q, so fullness looks one word ahead.
  logic [CntW-1:0] ptr_after;
  logic            full;
  assign ptr_after = ptr_q + CntW'(state_q == StWrite);
  assign full      = (ptr_after == CntW'(Depth));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_mode) state_d = StCollect;
      end
      StCollect: begin
        if (!load_mode) begin
          state_d = StIdle;
        end else if (load_byte_vld && !full && (byte_cnt_q == 2'd3)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = load_mode ? StCollect : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_we        = (state_q == StWrite);
    load_done     = done_q;
    load_words    = ptr_q;
    load_overflow = overflow_q;
  end

  // Loader datapath; byte_cnt is already 0 during WRITE, so a byte there lands in lane 0.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    ptr_d      = ptr_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    if (state_q == StIdle) begin
      if (load_mode) begin
        ptr_d      = '0;
        overflow_d = 1'b0;
        byte_cnt_d = 2'd0;
      end
    end else begin
      if (!load_mode) begin
        done_d = 1'b1;
      end else if (load_byte_vld) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = load_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      if (state_q == StWrite) ptr_d = ptr_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[ptr_q[ADDR_WIDTH-1:0]] <= word_q;
  end

  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  fetch_bad;
  logic                  bypass;
  assign fetch_idx = pc_addr[ADDR_WIDTH+1:2];
  assign fetch_bad = (pc_addr[1:0] != 2'b00) || ((pc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  // A fetch coinciding with the final WRITE sees the word being written.
  assign bypass    = mem_we && (ptr_q[ADDR_WIDTH-1:0] == fetch_idx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (load_mode) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (fetch_req) begin
      instr_valid <= 1'b1;
      fetch_fault <= fetch_bad;
      if (fetch_bad)   instruction <= NOP_WORD;
      else if (bypass) instruction <= word_q;
      else             instruction <= mem[fetch_idx];
    end else begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: a full-size and a 4-word instance share stimulus, and
// fetch results are matched against per-instance expectation queues.
module tb_imem_fetch_responder;

  localparam logic [31:0] Nop = 32'h0000_0000;

  typedef logic [7:0] byte_q_t [$];

  logic        clock, reset, fetch_req, load_mode, load_byte_vld;
  logic [31:0] pc_addr;
  logic [7:0]  load_byte;
  logic [31:0] b_instr, s_instr;
  logic        b_valid, s_valid, b_fault, s_fault, b_done, s_done, b_ovf, s_ovf;
  logic [14:0] b_words;
  logic [2:0]  s_words;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] sb_big [$];
  logic [32:0] sb_small [$];
  logic [31:0] mdl_big [int];
  logic [31:0] mdl_small [4];
  logic [32:0] e_big, e_small;
  byte_q_t     bq;

  imem_fetch_responder u_dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_addr(pc_addr),
    .instruction(b_instr), .instr_valid(b_valid), .fetch_fault(b_fault),
    .load_mode(load_mode), .load_byte_vld(load_byte_vld), .load_byte(load_byte),
    .load_done(b_done), .load_words(b_words), .load_overflow(b_ovf)
  );

  imem_fetch_responder #(.ADDR_WIDTH(2)) u_dut_small (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc_addr(pc_addr),
    .instruction(s_instr), .instr_valid(s_valid), .fetch_fault(s_fault),
    .load_mode(load_mode), .load_byte_vld(load_byte_vld), .load_byte(load_byte),
    .load_done(s_done), .load_words(s_words), .load_overflow(s_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [32:0] exp_big(input logic [31:0] pc);
    if (pc[1:0] != 2'b00 || pc[31:16] != 16'd0) return {1'b1, Nop};
    return {1'b0, mdl_big[int'(pc[15:2])]};
  endfunction

  function automatic logic [32:0] exp_small(input logic [31:0] pc);
    if (pc[1:0] != 2'b00 || pc[31:4] != 28'd0) return {1'b1, Nop};
    return {1'b0, mdl_small[pc[3:2]]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_req = 1'b1;
    pc_addr   = pc;
    sb_big.push_back(exp_big(pc));
    sb_small.push_back(exp_small(pc));
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_b_instr", b_instr, Nop);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_fault", b_fault, 0);
    check("rst_b_done", b_done, 0);
    check("rst_b_words", b_words, 0);
    check("rst_b_ovf", b_ovf, 0);
    check("rst_s_instr", s_instr, Nop);
    check("rst_s_words", s_words, 0);
    check("rst_s_ovf", s_ovf, 0);
  endtask

  task automatic load_session(input byte_q_t bytes, input bit exit_fetch,
                              input logic [31:0] exit_pc);
    int nw;
    load_mode = 1'b1;
    tick();
    foreach (bytes[i]) begin
      load_byte_vld = 1'b1;
      load_byte     = bytes[i];
      tick();
    end
    load_byte_vld = 1'b0;
    load_mode     = 1'b0;
    nw = bytes.size() / 4;
    for (int w = 0; w < nw; w++) begin
      mdl_big[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
      if (w < 4) mdl_small[w] = mdl_big[w];
    end
    if (exit_fetch) fetch(exit_pc);
    else tick();
    check("b_load_done_pulse", b_done, 1);
    check("s_load_done_pulse", s_done, 1);
    check("b_load_words", b_words, nw);
    check("s_load_words", s_words, (nw < 4) ? nw : 4);
    check("b_load_overflow", b_ovf, 0);
    check("s_load_overflow", s_ovf, bytes.size() > 16);
    tick();
    check("b_load_done_end", b_done, 0);
    check("s_load_done_end", s_done, 0);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (b_valid) begin
        check("b_expected_fetch", sb_big.size() != 0, 1);
        if (sb_big.size() != 0) begin
          e_big = sb_big.pop_front();
          check("b_instruction", b_instr, e_big[31:0]);
          check("b_fetch_fault", b_fault, e_big[32]);
        end
      end
      if (s_valid) begin
        check("s_expected_fetch", sb_small.size() != 0, 1);
        if (sb_small.size() != 0) begin
          e_small = sb_small.pop_front();
          check("s_instruction", s_instr, e_small[31:0]);
          check("s_fetch_fault", s_fault, e_small[32]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; fetch_req = 1'b0; load_mode = 1'b0; load_byte_vld = 1'b0;
    pc_addr = 32'd0; load_byte = 8'd0;
    #3;
    check_reset_outputs();
    tick();
    reset = 1'b0;

    // Two words, then the exit-cycle fetch of word 1 must see the just-written data.
    bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_session(bq, 1'b1, 32'h4);
    fetch(32'h0);
    fetch(32'h4);
    tick();
    check("idle_valid_low", b_valid, 0);
    check("idle_fault_low", b_fault, 0);
    check("idle_instr_held", b_instr, 32'hDEAD_BEEF);

    fetch(32'h0000_0006);
    fetch(32'h0001_0000);
    tick();

    // Partial trailing word is discarded; word 1 keeps its old contents.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    load_session(bq, 1'b0, 32'h0);
    fetch(32'h0);
    fetch(32'h4);
    tick();

    // 20 bytes overflow the 4-word instance but not the large one.
    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'hA0 + 8'(i));
    load_session(bq, 1'b1, 32'h10);
    for (int a = 0; a < 4; a++) fetch(32'(a * 4));
    tick();

    // Reset in the middle of a word.
    load_mode = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      load_byte_vld = 1'b1;
      load_byte     = 8'h5A;
      tick();
    end
    load_byte_vld = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs();
    load_mode = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_no_b_done", b_done, 0);
      check("rst_no_s_done", s_done, 0);
    end
    fetch(32'h8);
    fetch(32'hC);
    tick();

    // Fetch requests are ignored while programming.
    load_mode = 1'b1;
    fetch_req = 1'b1;
    pc_addr   = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_b_valid", b_valid, 0);
      check("stall_b_instr", b_instr, Nop);
      check("stall_s_valid", s_valid, 0);
    end
    fetch_req = 1'b0;
    load_mode = 1'b0;
    tick();
    check("empty_session_done", b_done, 1);
    check("empty_session_words", b_words, 0);
    tick();

    check("b_scoreboard_drained", sb_big.size(), 0);
    check("s_scoreboard_drained", sb_small.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
